fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: fetch_start  input  1  request to fetch the instruction at PC (driven in the control FETCH state).
REQ-004 SHALL have port: jmp_valid  input  1  redirect PC to jmp_base + jmp_offset.
REQ-005 SHALL have port: jmp_base  input  8  selected register value (A or B) for the jump target.
REQ-006 SHALL have port: jmp_offset  input  4  unsigned jump offset.
REQ-007 SHALL have port: halt  input  1  level halt request from the control unit.
REQ-008 SHALL have port: mem_req  output  1  instruction memory read request.
REQ-009 SHALL have port: mem_addr  output  8  instruction memory read address.
REQ-010 SHALL have port: mem_ack  input  1  memory read-data-valid strobe.
REQ-011 SHALL have port: mem_rdata  input  8  memory read data.
REQ-012 SHALL have port: instr  output  8  latched instruction feeding the control unit.
REQ-013 SHALL have port: instr_valid  output  1  one-cycle pulse when instr is updated.
REQ-014 SHALL have port: pc  output  8  current program counter.
REQ-015 SHALL have port: busy  output  1  fetch in flight.
REQ-016 SHALL have port: fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-017 SHALL implement states IDLE, WAIT, HALTED and ERROR; all outputs SHALL be registered.
REQ-018 In IDLE with halt=1: SHALL enter HALTED on the next edge; fetch_start and jmp_valid SHALL be ignored.
REQ-019 In IDLE with fetch_start=1, jmp_valid=0, halt=0: next edge SHALL set mem_req=1, mem_addr=pc and busy=1, clear the wait counter, and enter WAIT.
REQ-020 In IDLE with jmp_valid=1, halt=0: next edge SHALL set pc = (jmp_base + zero-extended jmp_offset) mod 256.
REQ-021 If jmp_valid and fetch_start are both 1 in IDLE: the jump SHALL take priority, and mem_addr and pc SHALL both be loaded with the jump target on the same edge that enters WAIT.
REQ-022 In WAIT: mem_req and mem_addr SHALL be held stable until an edge on which mem_ack=1 is sampled.
REQ-023 On the WAIT edge with mem_ack=1:
- instr <= mem_rdata, and instr_valid=1 for exactly that one following cycle
- pc <= pc+1, wrapping 0xFF to 0x00
- mem_req=0 and busy=0
- next state is HALTED if halt=1 on that edge, else IDLE
REQ-024 Minimum fetch latency: fetch_start at edge N, mem_ack sampled at edge N+1, instr_valid high in the cycle after edge N+1.
REQ-025 In WAIT, fetch_start and jmp_valid SHALL be ignored (no queuing); halt SHALL be deferred until the fetch completes.
REQ-026 A 4-bit wait counter SHALL increment on each WAIT edge with mem_ack=0. If mem_ack=0 on the edge where the counter equals 15, the block SHALL:
- set fetch_err=1
- set mem_req=0 and busy=0
- enter ERROR
REQ-027 ERROR and HALTED SHALL be terminal until reset; pc and instr SHALL hold their values; mem_req=0.
REQ-028 mem_ack sampled outside WAIT SHALL be ignored and SHALL not change instr.
REQ-029 instr SHALL hold its value between fetches; instr_valid SHALL be 0 in every cycle except that of REQ-023.

Reset
REQ-030 Reset has priority over all inputs. While reset=1, on each edge:
- pc=0x00, instr=0x00, mem_addr=0x00
- mem_req=0, instr_valid=0, busy=0, fetch_err=0
- wait counter=0, state=IDLE
REQ-031 Reset mid-WAIT SHALL abandon the fetch (mem_req=0 on the next edge), and a late mem_ack SHALL be ignored.

Verification
REQ-032 Reset, fetch_start pulse, mem_ack one cycle later with rdata=0x6A -> instr=0x6A, single instr_valid pulse, pc=0x01.
REQ-033 pc=0xFF, fetch and ack with rdata=0x11 -> pc=0x00, instr=0x11.
REQ-034 Same-cycle jmp_valid+fetch_start, jmp_base=0xF8, offset=0xA -> mem_addr=0x02, after ack pc=0x03.
REQ-035 Fetch with mem_ack never asserted -> fetch_err=1 after 16 WAIT edges, mem_req=0, fetch_start then ignored; reset clears fetch_err.
REQ-036 halt asserted during WAIT with ack 3 cycles later -> instr updated, then HALTED with pc frozen and later fetch_start ignored.
REQ-037 Reset pulsed mid-WAIT, followed by a late mem_ack=1 with rdata=0xFF -> instr=0x00, instr_valid never pulses, pc=0x00.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the program counter, issues single-beat reads to
// instruction memory, latches the returned byte and flags memory timeouts.
module fetch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_start,
    input  logic       jmp_valid,
    input  logic [7:0] jmp_base,
    input  logic [3:0] jmp_offset,
    input  logic       halt,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] instr,
    output logic       instr_valid,
    output logic [7:0] pc,
    output logic       busy,
    output logic       fetch_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [3:0] wait_cnt_reg;
    logic [7:0] jmp_target;

    // Jump target wraps modulo 256.
    assign jmp_target = jmp_base + {4'h0, jmp_offset};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            pc           <= 8'h00;
            instr        <= 8'h00;
            mem_addr     <= 8'h00;
            mem_req      <= 1'b0;
            instr_valid  <= 1'b0;
            busy         <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (halt) begin
                        state_reg <= HALTED;
                    end else begin
                        if (jmp_valid) begin
                            pc <= jmp_target;
                        end
                        if (fetch_start) begin
                            // A simultaneous jump fetches from the new target.
                            mem_addr     <= jmp_valid ? jmp_target : pc;
                            mem_req      <= 1'b1;
                            busy         <= 1'b1;
                            wait_cnt_reg <= 4'd0;
                            state_reg    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        instr       <= mem_rdata;
                        instr_valid <= 1'b1;
                        pc          <= pc + 8'd1;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        state_reg   <= halt ? HALTED : IDLE;
                    end else if (wait_cnt_reg == 4'd15) begin
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
